// File: rtl/mastermind_board_ctrl.sv
// Mastermind board sequencer: owns the guess matrix, peg cursor and guess counter.
// A submitted row is scored against a snapshot of the answer, one colour per cycle.
module mastermind_board_ctrl #(
  parameter int NUM_GUESSES = 6,
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int NUM_COLORS  = 6,
  localparam int IW         = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   start,
  input  logic [NUM_PEGS*COLOR_W-1:0]            correct_answer,
  input  logic [COLOR_W-1:0]                     current_color,
  input  logic                                   confirm_color,
  input  logic                                   check_guess,
  input  logic                                   btn_left,
  input  logic                                   btn_right,
  output logic [NUM_GUESSES*NUM_PEGS*COLOR_W-1:0] matrix_flat,
  output logic [IW-1:0]                          index,
  output logic [2:0]                             guess_num,
  output logic [2:0]                             black_cnt,
  output logic [2:0]                             white_cnt,
  output logic                                   score_valid,
  output logic                                   q_Start,
  output logic                                   q_Input,
  output logic                                   q_Check,
  output logic                                   q_DoneC,
  output logic                                   q_DoneNC
);

  typedef logic [NUM_PEGS-1:0][COLOR_W-1:0] row_t;

  typedef enum logic [2:0] {
    ST_START,
    ST_INPUT,
    ST_CHECK,
    ST_DONE_C,
    ST_DONE_NC
  } state_t;

  localparam logic [COLOR_W-1:0] MAX_COLOR  = COLOR_W'(NUM_COLORS);
  localparam logic [COLOR_W-1:0] ONE_COLOR  = COLOR_W'(1);
  localparam logic [IW-1:0]      ONE_IDX    = IW'(1);
  localparam logic [2:0]         LAST_GUESS = 3'(NUM_GUESSES - 1);
  localparam logic [2:0]         FULL_ROW   = 3'(NUM_PEGS);

  state_t                  state;
  state_t                  state_next;
  row_t [NUM_GUESSES-1:0]  board;
  row_t                    row_snap;
  row_t                    ans_snap;
  row_t                    answer;
  row_t                    cur_row;
  logic [2:0]              black_acc;
  logic [2:0]              total_acc;
  logic [COLOR_W-1:0]      col;
  logic [2:0]              row_cnt;
  logic [2:0]              ans_cnt;
  logic [2:0]              term;
  logic                    row_full;
  logic                    color_ok;
  logic                    accept_check;
  logic                    check_done;
  logic                    win;

  function automatic logic [2:0] count_color(input row_t r, input logic [COLOR_W-1:0] c);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PEGS; i++)
      if (r[i] == c) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] count_exact(input row_t a, input row_t b);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PEGS; i++)
      if (a[i] == b[i]) n = n + 3'd1;
    return n;
  endfunction

  assign answer      = correct_answer;
  assign cur_row     = board[guess_num];
  assign matrix_flat = board;

  always_comb begin
    row_full = 1'b1;
    for (int i = 0; i < NUM_PEGS; i++)
      if (cur_row[i] == '0) row_full = 1'b0;
  end

  // One colour's contribution to the total (exact + colour-only) match count.
  assign row_cnt = count_color(row_snap, col);
  assign ans_cnt = count_color(ans_snap, col);
  assign term    = (row_cnt < ans_cnt) ? row_cnt : ans_cnt;

  assign color_ok     = (current_color != '0) && (current_color <= MAX_COLOR);
  assign accept_check = (state == ST_INPUT) && check_guess && row_full;
  assign check_done   = (state == ST_CHECK) && (col == MAX_COLOR);
  assign win          = (black_acc == FULL_ROW);

  always_comb begin
    state_next = state;
    case (state)
      ST_START:   if (start) state_next = ST_INPUT;
      ST_INPUT:   if (accept_check) state_next = ST_CHECK;
      ST_CHECK:
        if (check_done) begin
          if (win)                          state_next = ST_DONE_C;
          else if (guess_num == LAST_GUESS) state_next = ST_DONE_NC;
          else                              state_next = ST_INPUT;
        end
      ST_DONE_C,
      ST_DONE_NC: if (start) state_next = ST_INPUT;
      default:    state_next = ST_START;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_START;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      board       <= '0;
      index       <= '0;
      guess_num   <= '0;
      black_cnt   <= '0;
      white_cnt   <= '0;
      score_valid <= 1'b0;
      row_snap    <= '0;
      ans_snap    <= '0;
      black_acc   <= '0;
      total_acc   <= '0;
      col         <= '0;
    end else begin
      score_valid <= 1'b0;
      case (state)
        ST_INPUT: begin
          // Only the highest-priority strobe present is considered.
          if (check_guess) begin
            if (row_full) begin
              row_snap  <= cur_row;
              ans_snap  <= answer;
              black_acc <= count_exact(cur_row, answer);
              total_acc <= '0;
              col       <= ONE_COLOR;
            end
          end else if (confirm_color) begin
            if (color_ok) begin
              board[guess_num][index] <= current_color;
              index                   <= index + ONE_IDX;
            end
          end else if (btn_right) begin
            index <= index + ONE_IDX;
          end else if (btn_left) begin
            index <= index - ONE_IDX;
          end
        end
        ST_CHECK: begin
          total_acc <= total_acc + term;
          col       <= col + ONE_COLOR;
          if (check_done) begin
            black_cnt   <= black_acc;
            white_cnt   <= total_acc + term - black_acc;
            score_valid <= 1'b1;
            if (!win && guess_num != LAST_GUESS) begin
              guess_num <= guess_num + 3'd1;
              index     <= '0;
            end
          end
        end
        ST_START,
        ST_DONE_C,
        ST_DONE_NC: begin
          if (start) begin
            board     <= '0;
            index     <= '0;
            guess_num <= '0;
            black_cnt <= '0;
            white_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign q_Start  = (state == ST_START);
  assign q_Input  = (state == ST_INPUT);
  assign q_Check  = (state == ST_CHECK);
  assign q_DoneC  = (state == ST_DONE_C);
  assign q_DoneNC = (state == ST_DONE_NC);

endmodule

// File: tb/tb_mastermind_board_ctrl.sv
// Scoreboard bench for mastermind_board_ctrl: directed scenarios followed by random play
// against an array-based model of the game rules.
module tb_mastermind_board_ctrl;

  typedef logic [71:0] val_t;
  typedef struct {
    int black;
    int white;
  } score_t;

  localparam int S_START  = 0;
  localparam int S_INPUT  = 1;
  localparam int S_CHECK  = 2;
  localparam int S_DONEC  = 3;
  localparam int S_DONENC = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [11:0] correct_answer;
  logic [2:0]  current_color;
  logic        confirm_color;
  logic        check_guess;
  logic        btn_left;
  logic        btn_right;
  logic [71:0] matrix_flat;
  logic [1:0]  index;
  logic [2:0]  guess_num;
  logic [2:0]  black_cnt;
  logic [2:0]  white_cnt;
  logic        score_valid;
  logic        q_Start;
  logic        q_Input;
  logic        q_Check;
  logic        q_DoneC;
  logic        q_DoneNC;

  int     checks = 0;
  int     errors = 0;
  score_t exp_q[$];

  int m_board[6][4];
  int m_idx;
  int m_guess;
  int m_state;
  int m_black;
  int m_white;
  int m_cd;
  bit m_sv;
  int p_black;
  int p_white;
  int p_state;

  mastermind_board_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .start          (start),
    .correct_answer (correct_answer),
    .current_color  (current_color),
    .confirm_color  (confirm_color),
    .check_guess    (check_guess),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .matrix_flat    (matrix_flat),
    .index          (index),
    .guess_num      (guess_num),
    .black_cnt      (black_cnt),
    .white_cnt      (white_cnt),
    .score_valid    (score_valid),
    .q_Start        (q_Start),
    .q_Input        (q_Input),
    .q_Check        (q_Check),
    .q_DoneC        (q_DoneC),
    .q_DoneNC       (q_DoneNC)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each score pulse must match the oldest outstanding expected score.
  always @(negedge Clk) begin
    score_t e;
    if (Reset === 1'b0 && score_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_score: got black=%0d white=%0d with no score pending",
                 black_cnt, white_cnt);
      end else begin
        e = exp_q.pop_front();
        checkVal("score_black", val_t'(black_cnt), val_t'(e.black));
        checkVal("score_white", val_t'(white_cnt), val_t'(e.white));
      end
    end
  end

  task automatic modelReset();
    foreach (m_board[g, p]) m_board[g][p] = 0;
    m_idx   = 0;
    m_guess = 0;
    m_state = S_START;
    m_black = 0;
    m_white = 0;
    m_cd    = 0;
    m_sv    = 1'b0;
  endtask

  task automatic modelClear();
    foreach (m_board[g, p]) m_board[g][p] = 0;
    m_idx   = 0;
    m_guess = 0;
    m_black = 0;
    m_white = 0;
  endtask

  // Scores a full row with colour histograms: total = sum of per-colour minima.
  task automatic modelScore(input logic [11:0] ans);
    int a[4];
    int hr[8];
    int ha[8];
    int blk;
    int tot;
    score_t s;
    blk = 0;
    tot = 0;
    foreach (hr[c]) begin
      hr[c] = 0;
      ha[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      a[i] = int'(ans[i*3 +: 3]);
      if (a[i] == m_board[m_guess][i]) blk++;
      hr[m_board[m_guess][i]]++;
      ha[a[i]]++;
    end
    for (int c = 1; c <= 6; c++) tot += (hr[c] < ha[c]) ? hr[c] : ha[c];
    p_black = blk;
    p_white = tot - blk;
    if (blk == 4)          p_state = S_DONEC;
    else if (m_guess == 5) p_state = S_DONENC;
    else                   p_state = S_INPUT;
    s.black = p_black;
    s.white = p_white;
    exp_q.push_back(s);
  endtask

  task automatic modelStep(input bit s, input bit cf, input bit ck, input bit bl, input bit br,
                           input int col, input logic [11:0] ans);
    bit full;
    m_sv = 1'b0;
    case (m_state)
      S_START: if (s) m_state = S_INPUT;
      S_INPUT: begin
        if (ck) begin
          full = 1'b1;
          for (int i = 0; i < 4; i++) if (m_board[m_guess][i] == 0) full = 1'b0;
          if (full) begin
            modelScore(ans);
            m_state = S_CHECK;
            m_cd    = 6;
          end
        end else if (cf) begin
          if (col >= 1 && col <= 6) begin
            m_board[m_guess][m_idx] = col;
            m_idx = (m_idx + 1) % 4;
          end
        end else if (br) begin
          m_idx = (m_idx + 1) % 4;
        end else if (bl) begin
          m_idx = (m_idx + 3) % 4;
        end
      end
      S_CHECK: begin
        m_cd--;
        if (m_cd == 0) begin
          m_black = p_black;
          m_white = p_white;
          m_sv    = 1'b1;
          m_state = p_state;
          if (p_state == S_INPUT) begin
            m_guess++;
            m_idx = 0;
          end
        end
      end
      default: begin
        if (s) begin
          modelClear();
          m_state = S_INPUT;
        end
      end
    endcase
  endtask

  task automatic checkOutput();
    val_t em;
    logic [4:0] ef;
    em = '0;
    for (int g = 0; g < 6; g++)
      for (int p = 0; p < 4; p++)
        em[(g*4+p)*3 +: 3] = 3'(m_board[g][p]);
    ef = 5'b10000 >> m_state;
    checkVal("state_flags", val_t'({q_Start, q_Input, q_Check, q_DoneC, q_DoneNC}), val_t'(ef));
    checkVal("matrix_flat", matrix_flat, em);
    checkVal("index", val_t'(index), val_t'(m_idx));
    checkVal("guess_num", val_t'(guess_num), val_t'(m_guess));
    checkVal("black_cnt", val_t'(black_cnt), val_t'(m_black));
    checkVal("white_cnt", val_t'(white_cnt), val_t'(m_white));
    checkVal("score_valid", val_t'(score_valid), val_t'(m_sv));
  endtask

  // Called at a falling edge: drive for one rising edge, then compare.
  task automatic applyStimulus(input bit s, input bit cf, input bit ck, input bit bl,
                               input bit br, input logic [2:0] col);
    start         = s;
    confirm_color = cf;
    check_guess   = ck;
    btn_left      = bl;
    btn_right     = br;
    current_color = col;
    @(negedge Clk);
    modelStep(s, cf, ck, bl, br, int'(col), correct_answer);
    start         = 1'b0;
    confirm_color = 1'b0;
    check_guess   = 1'b0;
    btn_left      = 1'b0;
    btn_right     = 1'b0;
    checkOutput();
  endtask

  task automatic applyReset(input int cycles);
    Reset         = 1'b1;
    start         = 1'b0;
    confirm_color = 1'b0;
    check_guess   = 1'b0;
    btn_left      = 1'b0;
    btn_right     = 1'b0;
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
    modelReset();
    exp_q.delete();
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic enterRow(input logic [2:0] c0, input logic [2:0] c1,
                          input logic [2:0] c2, input logic [2:0] c3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c3);
  endtask

  task automatic submitRow();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(6);
  endtask

  task automatic newAnswer();
    for (int i = 0; i < 4; i++) correct_answer[i*3 +: 3] = 3'($urandom_range(1, 6));
  endtask

  initial begin
    Reset          = 1'b1;
    start          = 1'b0;
    confirm_color  = 1'b0;
    check_guess    = 1'b0;
    btn_left       = 1'b0;
    btn_right      = 1'b0;
    current_color  = 3'd0;
    correct_answer = 12'd0;
    applyReset(2);
    checkVal("reset_q_Start", val_t'(q_Start), val_t'(1));
    checkVal("reset_matrix", matrix_flat, val_t'(0));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkVal("start_q_Input", val_t'(q_Input), val_t'(1));

    // Winning first guess.
    correct_answer = 12'b001_001_001_001;
    enterRow(3'd1, 3'd1, 3'd1, 3'd1);
    checkVal("row0_249", val_t'(matrix_flat[11:0]), val_t'(12'h249));
    checkVal("index_wrap", val_t'(index), val_t'(0));
    submitRow();
    checkVal("win_q_DoneC", val_t'(q_DoneC), val_t'(1));
    checkVal("win_black", val_t'(black_cnt), val_t'(4));

    // All-white score, then an incomplete row.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    correct_answer = 12'b100_011_010_001;
    enterRow(3'd4, 3'd3, 3'd2, 3'd1);
    submitRow();
    checkVal("white4", val_t'(white_cnt), val_t'(4));
    checkVal("guess1", val_t'(guess_num), val_t'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkVal("incomplete_ignored", val_t'(q_Input), val_t'(1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    submitRow();

    // Exhaust the remaining rows without winning.
    for (int r = 2; r < 6; r++) begin
      enterRow(3'd2, 3'd2, 3'd2, 3'd2);
      submitRow();
    end
    checkVal("lose_q_DoneNC", val_t'(q_DoneNC), val_t'(1));
    checkVal("lose_guess5", val_t'(guess_num), val_t'(5));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    checkVal("restart_matrix", matrix_flat, val_t'(0));

    // Simultaneous strobes, left wrap, reset during scoring.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
    checkVal("confirm_over_right", val_t'(index), val_t'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    checkVal("left_wrap", val_t'(index), val_t'(3));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(2);
    applyReset(1);
    checkVal("midcheck_reset_q_Start", val_t'(q_Start), val_t'(1));

    // Random play, biased towards the answer colour so wins occur.
    newAnswer();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [2:0] c;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) c = correct_answer[m_idx*3 +: 3];
      else                           c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        applyReset(1);
      end else if ((m_state == S_DONEC || m_state == S_DONENC || m_state == S_START) && r < 30) begin
        newAnswer();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c);
      end else if (r < 35) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c);
      else if (r < 45)     applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
      else if (r < 55)     applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c);
      else if (r < 68)     applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c);
      else if (r < 72)     applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c);
      else                 applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
    end
    idle(8);
    checkVal("pending_scores", val_t'(exp_q.size()), val_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
